// File: rtl/acc_drain_controller.sv
// Drains a block of consecutive accumulator words onto a valid/ready stream.
// Define ACC_DRAIN_RELU_EN to apply signed ReLU to the stream data at the FIFO output.
module acc_drain_controller #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              drain_start,
    input  logic [ADDR_W-1:0] drain_base_addr,
    input  logic [7:0]        drain_count,
    output logic              drain_busy,
    output logic              drain_done,
    output logic              acc_rd_en,
    output logic [ADDR_W-1:0] acc_rd_addr,
    input  logic [DATA_W-1:0] acc_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_index
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        total, issued, popped, push_idx;
    logic [RD_LAT-1:0] vld_pipe;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [7:0]        fifo_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  level, inflight;
    logic              push, pop, fifo_empty, fifo_full, credit_ok, start_ok;
    logic [DATA_W-1:0] head;

    // Every read in the latency pipe already owns a FIFO slot, so the sum is the credit in use.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    assign credit_ok   = ({1'b0, inflight} + {1'b0, level}) < (CNT_W+1)'(FIFO_DEPTH);
    assign acc_rd_en   = (state == READ) && (issued < total) && credit_ok;
    assign acc_rd_addr = rd_addr;
    assign start_ok    = (state == IDLE) && drain_start;
    assign drain_busy  = (state != IDLE);

    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == CNT_W'(FIFO_DEPTH));
    assign push        = vld_pipe[RD_LAT-1];
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign head        = fifo_data[rd_ptr];
    assign out_index   = out_valid ? fifo_idx[rd_ptr] : 8'd0;

`ifdef ACC_DRAIN_RELU_EN
    assign out_data = (!out_valid || head[DATA_W-1]) ? '0 : head;
`else
    assign out_data = out_valid ? head : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        case (state)
            IDLE:  if (drain_start) state_nxt = (drain_count == 8'd0) ? DONE : READ;
            READ:  if (acc_rd_en && (issued + 8'd1 == total)) state_nxt = FLUSH;
            FLUSH: if ((popped == total) && fifo_empty) state_nxt = DONE;
            DONE: begin
                drain_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr  <= '0;
            total    <= '0;
            issued   <= '0;
            popped   <= '0;
            push_idx <= '0;
        end else if (start_ok) begin
            rd_addr  <= drain_base_addr;
            total    <= drain_count;
            issued   <= '0;
            popped   <= '0;
            push_idx <= '0;
        end else begin
            if (acc_rd_en) begin
                rd_addr <= rd_addr + 1'b1;
                issued  <= issued + 8'd1;
            end
            if (pop)  popped   <= popped + 8'd1;
            if (push) push_idx <= push_idx + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= acc_rd_en;
            for (int i = 1; i < RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Storage needs no reset: out_valid gates everything read from it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= acc_rd_data;
            fifo_idx[wr_ptr]  <= push_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) assert (!(push && fifo_full))
            else $error("acc_drain_controller: FIFO push while full");
    end
`endif

endmodule

// File: doc/acc_drain_controller.md
Name: acc_drain_controller

Overview:
- Reader-side counterpart to the systolic controller's accumulator write port.
- After a matmul completes, it reads a block of consecutive accumulator entries and streams them out over a valid/ready interface toward the unified-buffer writer.
- Handles accumulator read latency with an internal FIFO and credit check, so backpressure never drops data.

Parameters:
- ADDR_W, 8, accumulator address width.
- DATA_W, 32, accumulator word width (signed two's complement).
- RD_LAT, 1, accumulator read latency in cycles, from acc_rd_en to acc_rd_data valid; legal range 1..3.
- FIFO_DEPTH, 4, output FIFO entries; power of two, must be >= RD_LAT+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- drain_start  in  1  start pulse; accepted only in IDLE.
- drain_base_addr  in  ADDR_W  first accumulator address to read.
- drain_count  in  8  number of words to read (0..255).
- drain_busy  out  1  high in any state other than IDLE.
- drain_done  out  1  one-cycle pulse when the last word is accepted downstream.
- acc_rd_en  out  1  accumulator read strobe.
- acc_rd_addr  out  ADDR_W  accumulator read address.
- acc_rd_data  in  DATA_W  read data, valid RD_LAT cycles after acc_rd_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  stream data.
- out_index  out  8  word offset (0..count-1) of out_data within the block.

Behaviour:
- Reset (async): state=IDLE; all counters, FIFO pointers and the latency pipe cleared. Outputs: drain_busy=0, drain_done=0, acc_rd_en=0, acc_rd_addr=0, out_valid=0, out_data=0, out_index=0.
- States: IDLE, READ, FLUSH, DONE.
- IDLE -> READ on drain_start. At that edge, latch drain_base_addr into rd_addr and drain_count into total; clear issued and popped.
- IDLE with drain_start and drain_count=0 -> DONE directly. No reads are issued.
- READ: acc_rd_en = (issued < total) && (inflight + fifo_level < FIFO_DEPTH).
  - inflight = reads issued whose data has not yet returned; tracked by an RD_LAT-deep valid shift pipe.
  - On each issue: rd_addr += 1 (wraps modulo 2^ADDR_W; 0xFF -> 0x00), issued += 1.
  - acc_rd_addr = rd_addr, combinational from the register.
- READ -> FLUSH when issued reaches total.
- Return path: when the pipe output is valid, capture acc_rd_data into the FIFO on that cycle. The credit check guarantees the FIFO never overflows.
- Overflow is a design error. Under simulation only, an assertion fires on a push while full.
- Output: out_valid = FIFO not empty; out_data and out_index come from the FIFO head.
  - Pop when out_valid && out_ready; popped += 1.
  - out_data and out_index hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop on the same cycle: both take effect and fifo_level is unchanged.
- FLUSH -> DONE when popped == total and the FIFO is empty.
- DONE: drain_done=1 for exactly one cycle, then -> IDLE. drain_busy=0 in the following cycle.
- Minimum latency, out_ready held high: first out_valid RD_LAT+1 cycles after drain_start. Steady throughput is one word per cycle.
- drain_start while busy: ignored; no relatch of address or count.
- Reset mid-operation: immediate return to IDLE. Data in flight and in the FIFO is discarded. acc_rd_data arriving after reset is ignored.

Optional Feature:
- Macro: ACC_DRAIN_RELU_EN.
- Defined: out_data = (head[DATA_W-1] ? 0 : head), i.e. signed ReLU applied at the FIFO output. No added latency.
- Undefined: out_data = raw FIFO head, bit-exact with the accumulator contents.

Test Plan:
- Basic drain: base=0x10, count=3, acc model returns 5/-7/9, out_ready=1.
  - Required: reads at 0x10, 0x11, 0x12 on consecutive cycles; out_index 0,1,2 with data 5,-7,9 (or 5,0,9 with ACC_DRAIN_RELU_EN); drain_done pulses once; drain_busy low the next cycle.
- Backpressure: count=8, out_ready=0 for 10 cycles, then 1.
  - Required: exactly FIFO_DEPTH (4) reads issued and the stream holds its first word stable.
  - After release: 8 words in order with none lost or duplicated; done pulses after the 8th handshake.
- Wrap: base=0xFE, count=4 -> read addresses 0xFE, 0xFF, 0x00, 0x01.
- Zero count: drain_start with count=0 -> acc_rd_en never asserted; drain_done one cycle after start; busy high for exactly 1 cycle.
- Busy start and mid-op reset: drain_start with base=0x40 during an active drain (base=0x00, count=5) is ignored and addresses continue 0x0n.
  - Then rst_n low mid-stream: all outputs 0 and state IDLE.
  - A fresh start afterwards (base=0x20, count=2) behaves like the basic case.
- Latency sweep: RD_LAT=1, 2, 3 with count=6 and random out_ready.
  - Required: the data sequence matches the memory model exactly in every configuration.
